router_sync_multi: RTL and testbench
====================================

Name: router_sync_multi

Overview:
- Parametrised successor to the 1x3 router synchronizer.
- Sits between the router FSM/register block and N output FIFOs.
- Latches the destination address from the header byte. Steers write enable and full status to or from the selected FIFO. Drives vld_out per port from FIFO empty flags.
- Issues a per-port soft reset when a valid port is not read within a programmable timeout. Adds illegal-address detection, which the 3-port version lacks.

Parameters:
- NUM_PORTS, 3, number of output FIFOs (2..8).
- ADDR_W, 2, width of the address field in data_in; must satisfy 2**ADDR_W >= NUM_PORTS.
- TIMEOUT, 30, consecutive unread-valid cycles before soft reset (>= 2).
- CNT_W, 5, timeout counter width; must hold TIMEOUT-1.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- detect_addr  in  1  header present; latch address this edge.
- data_in  in  ADDR_W  destination address field of the header.
- write_en_reg  in  1  FSM request to write the current byte.
- full  in  NUM_PORTS  per-FIFO full flags.
- empty  in  NUM_PORTS  per-FIFO empty flags.
- read_en  in  NUM_PORTS  per-port read enables from the output side.
- write_enb  out  NUM_PORTS  one-hot FIFO write enable.
- fifo_full  out  1  full flag of the addressed FIFO.
- addr_err  out  1  latched address is >= NUM_PORTS.
- vld_out  out  NUM_PORTS  per-port data valid.
- soft_reset  out  NUM_PORTS  per-FIFO soft reset pulse.

Behaviour:
- Reset (resetn low, asynchronous):
  - addr_reg = 0, addr_err = 0.
  - All timeout counters = 0.
  - soft_reset = 0.
  - Combinational outputs follow from these values.
- Address latch:
  - On a rising edge with detect_addr=1, addr_reg <= data_in.
  - In the same edge, addr_err <= (data_in >= NUM_PORTS).
  - Otherwise both hold.
  - New address is visible one cycle after detect_addr.
- write_enb (combinational from addr_reg):
  - If write_en_reg=1 and addr_err=0: write_enb = 1 << addr_reg.
  - Else: all zeros.
  - Never more than one bit set.
- fifo_full (combinational):
  - full[addr_reg] when addr_err=0.
  - Forced 1 when addr_err=1, which stalls the FSM on an illegal packet.
- vld_out[i] = ~empty[i] (combinational, zero latency).
- Timeout, per port i, independent counter cnt[i] evaluated every rising edge:
  - If vld_out[i]=1 and read_en[i]=0:
    - If cnt[i]==TIMEOUT-1: soft_reset[i] <= 1 and cnt[i] <= 0.
    - Else: cnt[i] <= cnt[i]+1 and soft_reset[i] <= 0.
  - Otherwise: cnt[i] <= 0 and soft_reset[i] <= 0.
- soft_reset timing:
  - Registered, one-cycle pulse.
  - Goes high after exactly TIMEOUT consecutive qualifying edges.
  - If the FIFO stays non-empty, it repeats every TIMEOUT cycles.
- Boundary conditions:
  - read_en[i] asserted on the terminal-count cycle: counter clears and no pulse is issued (read wins).
  - empty[i] rising mid-count: counter clears.
  - Ports never interact; simultaneous pulses on multiple ports are legal.
  - detect_addr and write_en_reg in the same cycle: write_enb uses the previous addr_reg.
  - resetn low mid-count or mid-pulse: soft_reset drops and counters clear immediately.

Optional Feature:
- Macro: ROUTER_SYNC_TIMEOUT_STATUS_EN.
- When defined:
  - Adds input clr_status [NUM_PORTS] and output timeout_status [NUM_PORTS].
  - timeout_status[i] is set on the edge where soft_reset[i] is asserted.
  - It is cleared on an edge with clr_status[i]=1; set wins if both occur.
  - Reset value is 0.
- When undefined: both ports and all associated logic are absent; all other behaviour is identical.

Test Plan:
- Reset and idle:
  - Stimulus: resetn low with empty=3'b111.
  - Response: write_enb=0, fifo_full=full[0], soft_reset=0, vld_out=0, addr_err=0.
- Address steering:
  - Stimulus: detect_addr=1 with data_in=2, then write_en_reg=1 and full=3'b011.
  - Response: write_enb=3'b100 and fifo_full=0. Switching full to 3'b100 gives fifo_full=1.
- Illegal address:
  - Stimulus: data_in=3 latched with NUM_PORTS=3, then write_en_reg=1.
  - Response: addr_err=1, write_enb=0, fifo_full=1. Relatching data_in=1 clears addr_err.
- Timeout fire:
  - Stimulus: empty=3'b110, read_en=0, held for 30 cycles.
  - Response: soft_reset[0] is high for one cycle after the 30th edge, then repeats 30 cycles later.
- Read rescue:
  - Stimulus: same as timeout fire, but read_en[0]=1 on cycle 30.
  - Response: no pulse, and the counter restarts from 0.
- Status (macro defined):
  - Stimulus: after a timeout on port 1, pulse clr_status=3'b010.
  - Response: timeout_status reads 3'b010 until the clear, then 3'b000.

Source files
------------

// File: rtl/router_sync_multi.sv
// router_sync_multi: N-port router synchronizer with per-port timeout soft reset; optional ROUTER_SYNC_TIMEOUT_STATUS_EN adds sticky timeout status
module router_sync_multi #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 2,
  parameter int TIMEOUT   = 30,
  parameter int CNT_W     = 5
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 detect_addr,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 write_en_reg,
  input  logic [NUM_PORTS-1:0] full,
  input  logic [NUM_PORTS-1:0] empty,
  input  logic [NUM_PORTS-1:0] read_en,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic                 fifo_full,
  output logic                 addr_err,
  output logic [NUM_PORTS-1:0] vld_out,
  output logic [NUM_PORTS-1:0] soft_reset
`ifdef ROUTER_SYNC_TIMEOUT_STATUS_EN
  ,
  input  logic [NUM_PORTS-1:0] clr_status,
  output logic [NUM_PORTS-1:0] timeout_status
`endif
);
  logic [ADDR_W-1:0]    r_addr;
  logic                 r_addr_err;
  logic [CNT_W-1:0]     r_cnt [NUM_PORTS];
  logic [NUM_PORTS-1:0] r_sr;
  logic [NUM_PORTS-1:0] w_wait;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      r_addr     <= '0;
      r_addr_err <= 1'b0;
    end else if (detect_addr) begin
      r_addr     <= data_in;
      r_addr_err <= int'(data_in) >= NUM_PORTS;
    end
  assign vld_out    = ~empty;
  assign w_wait     = vld_out & ~read_en;
  assign addr_err   = r_addr_err;
  assign write_enb  = (write_en_reg && !r_addr_err) ? NUM_PORTS'(1) << r_addr : '0;
  assign fifo_full  = r_addr_err ? 1'b1 : full[r_addr];
  assign soft_reset = r_sr;
  // Terminal count fires the pulse and restarts, so a stuck port repeats every TIMEOUT cycles
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      r_sr <= '0;
      for (int i = 0; i < NUM_PORTS; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        r_sr[i]  <= w_wait[i] && r_cnt[i] == CNT_W'(TIMEOUT - 1);
        r_cnt[i] <= (w_wait[i] && r_cnt[i] != CNT_W'(TIMEOUT - 1)) ? r_cnt[i] + 1'b1 : '0;
      end
    end
`ifdef ROUTER_SYNC_TIMEOUT_STATUS_EN
  logic [NUM_PORTS-1:0] r_status;
  logic [NUM_PORTS-1:0] w_fire;
  always_comb
    for (int i = 0; i < NUM_PORTS; i++) w_fire[i] = w_wait[i] && r_cnt[i] == CNT_W'(TIMEOUT - 1);
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) r_status <= '0;
    else r_status <= w_fire | (r_status & ~clr_status);
  assign timeout_status = r_status;
`endif
endmodule

// File: tb/tb_router_sync_multi.sv
// tb_router_sync_multi: randomized self-checking bench with a streak-based reference model
module tb_router_sync_multi;
  localparam int NP = 3;
  localparam int TO = 30;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic detect_addr = 1'b0;
  logic [1:0] data_in = '0;
  logic write_en_reg = 1'b0;
  logic [NP-1:0] full = '0, empty = '1, read_en = '0;
  logic [NP-1:0] write_enb, vld_out, soft_reset;
  logic fifo_full, addr_err;
`ifdef ROUTER_SYNC_TIMEOUT_STATUS_EN
  logic [NP-1:0] clr_status = '0;
  logic [NP-1:0] timeout_status;
  logic [NP-1:0] m_status = '0;
`endif
  int passed = 0, total = 0;
  int m_addr = 0;
  bit m_err = 0;
  int streak [NP];
  logic [NP-1:0] m_sr = '0;
  logic [NP-1:0] exp_we;
  logic exp_ff;

  router_sync_multi dut (
    .clock(clock), .resetn(resetn), .detect_addr(detect_addr), .data_in(data_in),
    .write_en_reg(write_en_reg), .full(full), .empty(empty), .read_en(read_en),
    .write_enb(write_enb), .fifo_full(fifo_full), .addr_err(addr_err),
    .vld_out(vld_out), .soft_reset(soft_reset)
`ifdef ROUTER_SYNC_TIMEOUT_STATUS_EN
    , .clr_status(clr_status), .timeout_status(timeout_status)
`endif
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    m_addr = 0;
    m_err = 0;
    m_sr = '0;
    for (int i = 0; i < NP; i++) streak[i] = 0;
`ifdef ROUTER_SYNC_TIMEOUT_STATUS_EN
    m_status = '0;
`endif
  endtask

  // A pulse is due whenever the unread-valid streak reaches a multiple of TO
  task automatic tick();
    @(posedge clock);
    if (!resetn) model_reset();
    else begin
      for (int i = 0; i < NP; i++) begin
        if (!empty[i] && !read_en[i]) begin
          streak[i]++;
          m_sr[i] = (streak[i] % TO) == 0;
        end else begin
          streak[i] = 0;
          m_sr[i] = 1'b0;
        end
      end
`ifdef ROUTER_SYNC_TIMEOUT_STATUS_EN
      m_status = m_sr | (m_status & ~clr_status);
`endif
      if (detect_addr) begin
        m_addr = int'(data_in);
        m_err = m_addr >= NP;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    empty = 3'b111;
    full = 3'($urandom_range(0, 7));
    #1;
    total++; if (write_enb !== 3'b000) $display("FAIL reset_write_enb got=%b want=000", write_enb); else passed++;
    total++; if (fifo_full !== full[0]) $display("FAIL reset_fifo_full got=%b want=%b", fifo_full, full[0]); else passed++;
    total++; if (soft_reset !== 3'b000) $display("FAIL reset_soft_reset got=%b want=000", soft_reset); else passed++;
    total++; if (vld_out !== 3'b000) $display("FAIL reset_vld_out got=%b want=000", vld_out); else passed++;
    total++; if (addr_err !== 1'b0) $display("FAIL reset_addr_err got=%b want=0", addr_err); else passed++;
    tick();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_steering();
    detect_addr = 1'b1; data_in = 2'd2;
    tick();
    detect_addr = 1'b0; write_en_reg = 1'b1; full = 3'b011;
    #1;
    total++; if (write_enb !== 3'b100) $display("FAIL steer_write_enb got=%b want=100", write_enb); else passed++;
    total++; if (fifo_full !== 1'b0) $display("FAIL steer_fifo_full_lo got=%b want=0", fifo_full); else passed++;
    full = 3'b100;
    #1;
    total++; if (fifo_full !== 1'b1) $display("FAIL steer_fifo_full_hi got=%b want=1", fifo_full); else passed++;
    detect_addr = 1'b1; data_in = 2'd0;
    #1;
    total++; if (write_enb !== 3'b100) $display("FAIL steer_same_cycle got=%b want=100", write_enb); else passed++;
    tick();
    detect_addr = 1'b0;
    #1;
    total++; if (write_enb !== 3'b001) $display("FAIL steer_new_addr got=%b want=001", write_enb); else passed++;
    write_en_reg = 1'b0;
    #1;
    total++; if (write_enb !== 3'b000) $display("FAIL steer_no_write got=%b want=000", write_enb); else passed++;
  endtask

  task automatic test_illegal();
    full = 3'b000;
    detect_addr = 1'b1; data_in = 2'd3;
    tick();
    detect_addr = 1'b0; write_en_reg = 1'b1;
    #1;
    total++; if (addr_err !== 1'b1) $display("FAIL illegal_addr_err got=%b want=1", addr_err); else passed++;
    total++; if (write_enb !== 3'b000) $display("FAIL illegal_write_enb got=%b want=000", write_enb); else passed++;
    total++; if (fifo_full !== 1'b1) $display("FAIL illegal_fifo_full got=%b want=1", fifo_full); else passed++;
    detect_addr = 1'b1; data_in = 2'd1;
    tick();
    detect_addr = 1'b0;
    #1;
    total++; if (addr_err !== 1'b0) $display("FAIL illegal_clear got=%b want=0", addr_err); else passed++;
    total++; if (write_enb !== 3'b010) $display("FAIL illegal_relatch_we got=%b want=010", write_enb); else passed++;
    write_en_reg = 1'b0;
  endtask

  task automatic test_timeout_fire();
    empty = 3'b111; read_en = '0;
    tick();
    empty = 3'b110;
    for (int k = 1; k <= 2 * TO + 1; k++) begin
      tick();
      total++;
      if (soft_reset !== ((k % TO == 0) ? 3'b001 : 3'b000))
        $display("FAIL timeout_fire k=%0d got=%b want=%b", k, soft_reset, (k % TO == 0) ? 3'b001 : 3'b000);
      else passed++;
    end
    empty = 3'b111;
    tick();
  endtask

  task automatic test_read_rescue();
    empty = 3'b110; read_en = '0;
    for (int k = 1; k <= 2 * TO; k++) begin
      read_en = (k == TO) ? 3'b001 : 3'b000;
      tick();
      total++;
      if (soft_reset !== ((k == 2 * TO) ? 3'b001 : 3'b000))
        $display("FAIL read_rescue k=%0d got=%b want=%b", k, soft_reset, (k == 2 * TO) ? 3'b001 : 3'b000);
      else passed++;
    end
    read_en = '0; empty = 3'b111;
    tick();
  endtask

  task automatic test_multi_port();
    empty = 3'b000;
    for (int k = 1; k <= TO; k++) tick();
    total++; if (soft_reset !== 3'b111) $display("FAIL multi_port got=%b want=111", soft_reset); else passed++;
    empty = 3'b111;
    tick();
  endtask

  task automatic test_async_reset();
    empty = 3'b110;
    for (int k = 0; k < 10; k++) tick();
    #2 resetn = 1'b0;
    #1;
    total++; if (soft_reset !== 3'b000) $display("FAIL async_mid_count got=%b want=000", soft_reset); else passed++;
    tick();
    resetn = 1'b1;
    for (int k = 0; k < TO && !m_sr[0]; k++) tick();
    total++; if (soft_reset !== 3'b001) $display("FAIL async_pulse got=%b want=001", soft_reset); else passed++;
    #2 resetn = 1'b0;
    #1;
    total++; if (soft_reset !== 3'b000) $display("FAIL async_mid_pulse got=%b want=000", soft_reset); else passed++;
    tick();
    resetn = 1'b1;
    empty = 3'b111;
    tick();
  endtask

`ifdef ROUTER_SYNC_TIMEOUT_STATUS_EN
  task automatic test_status();
    empty = 3'b101;
    for (int k = 0; k < TO; k++) tick();
    empty = 3'b111;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (timeout_status !== 3'b010) $display("FAIL status_set got=%b want=010", timeout_status); else passed++;
    end
    clr_status = 3'b010;
    tick();
    clr_status = '0;
    total++; if (timeout_status !== 3'b000) $display("FAIL status_clear got=%b want=000", timeout_status); else passed++;
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      detect_addr = $urandom_range(0, 7) == 0;
      data_in = 2'($urandom_range(0, 3));
      write_en_reg = 1'($urandom);
      full = 3'($urandom);
      for (int i = 0; i < NP; i++) begin
        empty[i] = $urandom_range(0, 40) == 0 ? ~empty[i] : empty[i];
        read_en[i] = $urandom_range(0, 25) == 0;
      end
`ifdef ROUTER_SYNC_TIMEOUT_STATUS_EN
      clr_status = 3'($urandom_range(0, 7) == 0 ? $urandom : 0);
`endif
      #1;
      exp_we = (write_en_reg && !m_err) ? 3'(1 << m_addr) : 3'b000;
      exp_ff = m_err ? 1'b1 : full[m_addr];
      total++; if (write_enb !== exp_we) $display("FAIL rnd_write_enb n=%0d got=%b want=%b", n, write_enb, exp_we); else passed++;
      total++; if (fifo_full !== exp_ff) $display("FAIL rnd_fifo_full n=%0d got=%b want=%b", n, fifo_full, exp_ff); else passed++;
      total++; if (vld_out !== ~empty) $display("FAIL rnd_vld_out n=%0d got=%b want=%b", n, vld_out, ~empty); else passed++;
      tick();
      total++; if (soft_reset !== m_sr) $display("FAIL rnd_soft_reset n=%0d got=%b want=%b", n, soft_reset, m_sr); else passed++;
      total++; if (addr_err !== m_err) $display("FAIL rnd_addr_err n=%0d got=%b want=%b", n, addr_err, m_err); else passed++;
`ifdef ROUTER_SYNC_TIMEOUT_STATUS_EN
      total++; if (timeout_status !== m_status) $display("FAIL rnd_status n=%0d got=%b want=%b", n, timeout_status, m_status); else passed++;
`endif
    end
  endtask

  initial begin
    model_reset();
    #3;
    test_reset();
    test_steering();
    test_illegal();
    test_timeout_fire();
    test_read_rescue();
    test_multi_port();
    test_async_reset();
`ifdef ROUTER_SYNC_TIMEOUT_STATUS_EN
    test_status();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
